// File: rtl/counter_sequencer.sv
// Command-driven up/down counter sequencer with LED tap.
// Define COUNTER_SEQUENCER_SATURATE_EN to saturate at the ends of the range.
module counter_sequencer #(
    parameter int WIDTH   = 32,
    parameter int LED_LSB = 22
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_arg,
    input  logic             abort,
    output logic [WIDTH-1:0] count,
    output logic [3:0]       io_led,
    output logic             direction,
    output logic             busy,
    output logic             done,
    output logic             sat
);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_UP   = 2'b01;
    localparam logic [1:0] OP_DOWN = 2'b10;
    localparam logic [1:0] OP_NOP  = 2'b11;

    localparam logic [WIDTH-1:0] ZERO = '0;
    localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
`ifdef COUNTER_SEQUENCER_SATURATE_EN
    localparam logic [WIDTH-1:0] MAX  = '1;
`endif

    state_t           state;
    logic [WIDTH-1:0] remaining;
    logic             accept;
    logic             last;
    logic [WIDTH-1:0] next_count;
`ifdef COUNTER_SEQUENCER_SATURATE_EN
    logic             sat_r;
    logic             at_end;
`endif

    assign cmd_ready = (state == IDLE);
    assign accept    = cmd_valid && cmd_ready;
    assign last      = (remaining == ONE);
    assign io_led    = count[LED_LSB+3:LED_LSB];

    // One step in the latched direction, modulo 2^WIDTH.
    assign next_count = direction ? count + ONE : count - ONE;

`ifdef COUNTER_SEQUENCER_SATURATE_EN
    // A step that would leave the range ends the run instead.
    assign at_end = direction ? (count == MAX) : (count == ZERO);
    assign sat    = sat_r;
`else
    assign sat    = 1'b0;
`endif

    // Sequencer FSM: command decode in IDLE, stepping in RUN.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            count     <= '0;
            remaining <= '0;
            direction <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
`ifdef COUNTER_SEQUENCER_SATURATE_EN
            sat_r     <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
`ifdef COUNTER_SEQUENCER_SATURATE_EN
            sat_r <= 1'b0;
`endif
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        unique case (cmd_op)
                            OP_LOAD: count <= cmd_arg;
                            OP_UP, OP_DOWN: begin
                                direction <= (cmd_op == OP_UP);
                                if (cmd_arg == ZERO) begin
                                    done <= 1'b1;
                                end else begin
                                    remaining <= cmd_arg;
                                    state     <= RUN;
                                    busy      <= 1'b1;
                                end
                            end
                            OP_NOP: ;
                            default: ;
                        endcase
                    end
                end
                RUN: begin
                    if (abort) begin
                        state     <= IDLE;
                        busy      <= 1'b0;
                        remaining <= '0;
`ifdef COUNTER_SEQUENCER_SATURATE_EN
                    end else if (at_end) begin
                        state     <= IDLE;
                        busy      <= 1'b0;
                        remaining <= '0;
                        done      <= 1'b1;
                        sat_r     <= 1'b1;
`endif
                    end else begin
                        count     <= next_count;
                        remaining <= remaining - ONE;
                        if (last) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_counter_sequencer.sv
// Directed-vector bench for counter_sequencer.
// Expected values are hand-computed per test.
module tb_counter_sequencer;

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [31:0] cmd_arg;
    logic        abort;
    logic [31:0] count;
    logic [3:0]  io_led;
    logic        direction;
    logic        busy;
    logic        done;
    logic        sat;

    int nvec;
    int nerr;

    counter_sequencer #(
        .WIDTH   (32),
        .LED_LSB (22)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_arg   (cmd_arg),
        .abort     (abort),
        .count     (count),
        .io_led    (io_led),
        .direction (direction),
        .busy      (busy),
        .done      (done),
        .sat       (sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        nvec++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Advance one edge; sample 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one command for a single edge.
    task automatic issue(input logic [1:0] op,
                         input logic [31:0] arg);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_arg   = arg;
        tick();
        cmd_valid = 1'b0;
        cmd_op    = 2'b11;
    endtask

    initial begin
        nvec      = 0;
        nerr      = 0;
        rst       = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 2'b11;
        cmd_arg   = '0;
        abort     = 1'b0;
        tick();
        tick();

        chk("rst_count", count, 32'h0);
        chk("rst_busy", {31'b0, busy}, 32'h0);
        chk("rst_done", {31'b0, done}, 32'h0);
        chk("rst_sat", {31'b0, sat}, 32'h0);
        chk("rst_ready", {31'b0, cmd_ready}, 32'h1);
        chk("rst_dir", {31'b0, direction}, 32'h1);
        chk("rst_led", {28'b0, io_led}, 32'h0);
        rst = 1'b1;
        tick();

        // LOAD then a single UP step across the LED tap
        issue(2'b00, 32'h003F_FFFF);
        chk("ld_count", count, 32'h003F_FFFF);
        chk("ld_done", {31'b0, done}, 32'h0);
        issue(2'b01, 32'd1);
        chk("up1_acc_busy", {31'b0, busy}, 32'h1);
        chk("up1_acc_cnt", count, 32'h003F_FFFF);
        chk("up1_acc_rdy", {31'b0, cmd_ready}, 32'h0);
        tick();
        chk("up1_count", count, 32'h0040_0000);
        chk("up1_led", {28'b0, io_led}, 32'h1);
        chk("up1_busy", {31'b0, busy}, 32'h0);
        chk("up1_done", {31'b0, done}, 32'h1);
        tick();
        chk("up1_done_off", {31'b0, done}, 32'h0);

        // DOWN run of 4 from 10
        issue(2'b00, 32'd10);
        issue(2'b10, 32'd4);
        chk("dn_acc_cnt", count, 32'd10);
        chk("dn_dir", {31'b0, direction}, 32'h0);
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk("dn_step", count, 32'(10 - i));
            chk("dn_done", {31'b0, done},
                (i == 4) ? 32'h1 : 32'h0);
        end
        tick();
        chk("dn_done_off", {31'b0, done}, 32'h0);

        // Abort after 5 RUN edges
        issue(2'b00, 32'd0);
        issue(2'b01, 32'd100);
        for (int i = 0; i < 5; i++) tick();
        chk("ab_pre", count, 32'd5);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("ab_count", count, 32'd5);
        chk("ab_done", {31'b0, done}, 32'h0);
        chk("ab_busy", {31'b0, busy}, 32'h0);
        chk("ab_ready", {31'b0, cmd_ready}, 32'h1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("ab_idle_cnt", count, 32'd5);
        chk("ab_idle_rdy", {31'b0, cmd_ready}, 32'h1);

`ifdef COUNTER_SEQUENCER_SATURATE_EN
        // DOWN past zero saturates after 2 edges
        issue(2'b00, 32'd1);
        issue(2'b10, 32'd5);
        tick();
        chk("sat_e1_cnt", count, 32'd0);
        chk("sat_e1_done", {31'b0, done}, 32'h0);
        tick();
        chk("sat_e2_cnt", count, 32'd0);
        chk("sat_e2_done", {31'b0, done}, 32'h1);
        chk("sat_e2_sat", {31'b0, sat}, 32'h1);
        chk("sat_e2_busy", {31'b0, busy}, 32'h0);
        tick();
        chk("sat_off", {31'b0, sat}, 32'h0);
`else
        // UP past max wraps through zero
        issue(2'b00, 32'hFFFF_FFFF);
        issue(2'b01, 32'd2);
        tick();
        chk("wrap_e1", count, 32'd0);
        tick();
        chk("wrap_e2", count, 32'd1);
        chk("wrap_done", {31'b0, done}, 32'h1);
        chk("wrap_sat", {31'b0, sat}, 32'h0);
`endif

        // Back-to-back with cmd_valid held high
        issue(2'b00, 32'h50);
        cmd_valid = 1'b1;
        cmd_op    = 2'b01;
        cmd_arg   = 32'd3;
        tick();
        chk("bb_up_busy", {31'b0, busy}, 32'h1);
        cmd_op    = 2'b10;
        for (int i = 1; i <= 3; i++) begin
            tick();
            chk("bb_up_step", count, 32'(32'h50 + i));
        end
        chk("bb_up_done", {31'b0, done}, 32'h1);
        chk("bb_up_rdy", {31'b0, cmd_ready}, 32'h1);
        tick();
        cmd_valid = 1'b0;
        cmd_op    = 2'b11;
        chk("bb_dn_busy", {31'b0, busy}, 32'h1);
        chk("bb_dn_dir", {31'b0, direction}, 32'h0);
        chk("bb_dn_cnt", count, 32'h53);
        for (int i = 0; i < 3; i++) tick();
        chk("bb_final", count, 32'h50);
        chk("bb_dn_done", {31'b0, done}, 32'h1);

        // N = 0: immediate done, count unchanged
        issue(2'b01, 32'd0);
        chk("n0_done", {31'b0, done}, 32'h1);
        chk("n0_busy", {31'b0, busy}, 32'h0);
        chk("n0_cnt", count, 32'h50);
        chk("n0_dir", {31'b0, direction}, 32'h1);
        issue(2'b11, 32'd7);
        chk("nop_cnt", count, 32'h50);
        chk("nop_done", {31'b0, done}, 32'h0);

        // Asynchronous reset mid-run at 0x123
        issue(2'b00, 32'h120);
        issue(2'b01, 32'd10);
        for (int i = 0; i < 3; i++) tick();
        chk("mr_pre", count, 32'h123);
        #1 rst = 1'b0;
        #1;
        chk("mr_cnt", count, 32'h0);
        chk("mr_busy", {31'b0, busy}, 32'h0);
        chk("mr_led", {28'b0, io_led}, 32'h0);
        chk("mr_rdy", {31'b0, cmd_ready}, 32'h1);
        tick();
        rst = 1'b1;
        issue(2'b00, 32'h77);
        chk("mr_accept", count, 32'h77);
        chk("mr_done", {31'b0, done}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 nvec, nerr);
        $finish;
    end

endmodule

// File: doc/counter_sequencer.md
COUNTER_SEQUENCER -- requirements
Module: counter_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 32: counter width in bits (min 8).
REQ-002 SHALL have parameter LED_LSB, default 22: index of the lowest counter bit driven to io_led (LED_LSB+3 < WIDTH).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port cmd_valid  input  1  command offered.
REQ-006 SHALL have port cmd_ready  output  1  command accepted when high together with cmd_valid.
REQ-007 SHALL have port cmd_op  input  2  00 LOAD, 01 UP, 10 DOWN, 11 NOP.
REQ-008 SHALL have port cmd_arg  input  WIDTH  load value (LOAD) or step count N (UP/DOWN).
REQ-009 SHALL have port abort  input  1  terminate a running UP/DOWN.
REQ-010 SHALL have port count  output  WIDTH  current counter value.
REQ-011 SHALL have port io_led  output  4  count[LED_LSB+3:LED_LSB], combinational from count.
REQ-012 SHALL have port direction  output  1  1 = last run was UP, 0 = DOWN.
REQ-013 SHALL have port busy  output  1  high while in RUN.
REQ-014 SHALL have port done  output  1  one-cycle pulse on run completion.
REQ-015 SHALL have port sat  output  1  one-cycle pulse when a run ends by saturation.

Function
REQ-016 SHALL implement two states: IDLE and RUN.
REQ-017 SHALL drive cmd_ready = 1 in IDLE and 0 in RUN; a transfer occurs on an edge with cmd_valid && cmd_ready.
REQ-018 SHALL, on LOAD transfer: count <= cmd_arg at that edge; remain in IDLE; no done pulse.
REQ-019 SHALL, on UP/DOWN transfer with N > 0: latch direction, load a remaining counter with N, and enter RUN at that edge; count is not changed at the accept edge.
REQ-020 SHALL, on UP/DOWN transfer with N = 0: remain in IDLE; update direction; assert done for one cycle.
REQ-021 SHALL treat a NOP transfer as a no-op.
REQ-022 SHALL, on each RUN edge without abort: step count by +1 (UP) or -1 (DOWN) and decrement remaining.
REQ-023 SHALL, at the RUN edge where remaining is 1: perform the final step, return to IDLE, and set done = 1 for the next cycle only, so that count = start ± N after exactly N RUN edges.
REQ-024 SHALL, on a RUN edge with abort = 1: not step, return to IDLE, and not assert done; abort wins over a simultaneous final step.
REQ-025 SHALL ignore abort in IDLE.
REQ-026 SHALL, with saturation disabled, wrap count modulo 2^WIDTH (max+1 -> 0, 0-1 -> max).
REQ-027 SHALL keep cmd_ready low in RUN, so that a new command is accepted no earlier than the first IDLE cycle after done.

Reset
REQ-028 SHALL, while rst = 0, immediately force: state IDLE, count 0, remaining 0, direction 1, busy 0, done 0, sat 0; consequently io_led = 0 and cmd_ready = 1.
REQ-029 SHALL, on reset asserted mid-run, discard the run with no done pulse, and SHALL accept commands on the first edge after rst returns to 1.

Configuration
REQ-030 SHALL, when macro COUNTER_SEQUENCER_SATURATE_EN is defined: hold count at max on an UP step from max (or at 0 on a DOWN step from 0), end the run at that edge, and pulse both done and sat for one cycle.
REQ-031 SHALL, when COUNTER_SEQUENCER_SATURATE_EN is undefined: wrap per REQ-026 and tie sat constantly to 0.

Verification
REQ-032 SHALL verify reset: rst = 0 mid-run with count = 0x123 -> count = 0, busy = 0, io_led = 0 without a clock edge; the first command after release is accepted.
REQ-033 SHALL verify LOAD then step: LOAD 0x003FFFFF, then UP 1 -> count = 0x00400000, io_led = 1, done pulses once, busy high exactly 1 cycle.
REQ-034 SHALL verify a DOWN run: LOAD 10, DOWN 4 -> count 9, 8, 7, 6 on consecutive edges; done on the cycle after 6; direction = 0.
REQ-035 SHALL verify abort: LOAD 0, UP 100, abort after 5 RUN edges -> count = 5, no done, cmd_ready = 1 next cycle.
REQ-036 SHALL verify the boundary without the macro: LOAD 0xFFFFFFFF, UP 2 -> count = 1, sat = 0; with the macro: LOAD 1, DOWN 5 -> count = 0, done and sat pulse together after 2 RUN edges.
REQ-037 SHALL verify back-to-back commands: cmd_valid held high with UP 3 then DOWN 3 -> the second command is accepted in the cycle after done and count returns to its start value; a command with N = 0 -> done pulse, count unchanged.
